// File: rtl/seg7_scan_decoder.sv
// Snoops a multiplexed common-anode 7-segment bus and recovers the hex nibble on each digit.
// Each digit is accepted once per stable run and collected into a frame with a completion strobe.
module seg7_scan_decoder #(
   parameter int NUM_DIGITS    = 4,
   parameter int STABLE_CYCLES = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [6:0]              seg_n,
   input  logic [NUM_DIGITS-1:0]   dig_n,
   output logic [4*NUM_DIGITS-1:0] value,
   output logic [NUM_DIGITS-1:0]   digit_err,
   output logic                    frame_valid,
   output logic                    frame_stb
);

   localparam logic [7:0]            STABLE_MAX = 8'(STABLE_CYCLES);
   localparam logic [NUM_DIGITS-1:0] ALL_SEEN   = '1;

   logic [6:0]            seg_q;
   logic [NUM_DIGITS-1:0] dig_q;
   logic [6:0]            seg_prev;
   logic [NUM_DIGITS-1:0] dig_prev;
   logic [7:0]            stable_cnt;
   logic [7:0]            stable_cnt_next;
   logic [NUM_DIGITS-1:0] sel;
   logic [NUM_DIGITS-1:0] seen;
   logic [NUM_DIGITS-1:0] seen_next;
   logic                  qualified;
   logic                  same_as_prev;
   logic                  accept;
   logic                  glyph_ok;
   logic [3:0]            glyph_nib;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         seg_q    <= '0;
         dig_q    <= '0;
         seg_prev <= '0;
         dig_prev <= '0;
      end else begin
         seg_q    <= seg_n;
         dig_q    <= dig_n;
         seg_prev <= seg_q;
         dig_prev <= dig_q;
      end
   end

   // A count of zero marks "no qualified sample last cycle", so a match against stale prev data restarts at 1.
   always_comb begin
      sel             = ~dig_q;
      qualified       = $onehot(sel);
      same_as_prev    = (seg_q == seg_prev) && (dig_q == dig_prev);
      stable_cnt_next = '0;
      if (qualified) begin
         if (same_as_prev && (stable_cnt != '0)) begin
            if (stable_cnt == STABLE_MAX) begin
               stable_cnt_next = STABLE_MAX;
            end else begin
               stable_cnt_next = stable_cnt + 8'd1;
            end
         end else begin
            stable_cnt_next = 8'd1;
         end
      end
      accept = qualified && (stable_cnt_next == STABLE_MAX) && (stable_cnt != STABLE_MAX);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stable_cnt <= '0;
      end else begin
         stable_cnt <= stable_cnt_next;
      end
   end

   always_comb begin
      glyph_ok  = 1'b1;
      glyph_nib = 4'h0;
      case (seg_q)
         7'b0000001: glyph_nib = 4'h0;
         7'b1001111: glyph_nib = 4'h1;
         7'b0010010: glyph_nib = 4'h2;
         7'b0000110: glyph_nib = 4'h3;
         7'b1001100: glyph_nib = 4'h4;
         7'b0100100: glyph_nib = 4'h5;
         7'b0100000: glyph_nib = 4'h6;
         7'b0001111: glyph_nib = 4'h7;
         7'b0000000: glyph_nib = 4'h8;
         7'b0001100: glyph_nib = 4'h9;
         7'b0001000: glyph_nib = 4'hA;
         7'b1100000: glyph_nib = 4'hB;
         7'b0110001: glyph_nib = 4'hC;
         7'b1000010: glyph_nib = 4'hD;
         7'b0110000: glyph_nib = 4'hE;
         7'b0111000: glyph_nib = 4'hF;
         default:    glyph_ok  = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         value     <= '0;
         digit_err <= '0;
      end else begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (accept && sel[i]) begin
               if (glyph_ok) begin
                  value[4*i +: 4] <= glyph_nib;
                  digit_err[i]    <= 1'b0;
               end else begin
                  digit_err[i]    <= 1'b1;
               end
            end
         end
      end
   end

   // An accept landing on the clearing cycle keeps its bit so it counts toward the next frame.
   always_comb begin
      seen_next = (seen == ALL_SEEN) ? '0 : seen;
      if (accept) begin
         seen_next = seen_next | sel;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         seen        <= '0;
         frame_stb   <= 1'b0;
         frame_valid <= 1'b0;
      end else begin
         seen      <= seen_next;
         frame_stb <= (seen == ALL_SEEN);
         if (seen == ALL_SEEN) begin
            frame_valid <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: directed scenarios with literal expectations, then random scanning
// checked every cycle against a history-based model of the stability and frame rules.
module tb_seg7_scan_decoder;

   localparam int N      = 4;
   localparam int STABLE = 8;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [6:0]       seg_n;
   logic [N-1:0]     dig_n;
   logic [4*N-1:0]   value;
   logic [N-1:0]     digit_err;
   logic             frame_valid;
   logic             frame_stb;

   int vectors     = 0;
   int miscompares = 0;

   logic [6:0] glyph [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                              7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                              7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
                              7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

   logic           model_on = 1'b0;
   logic [4*N-1:0] m_value;
   logic [N-1:0]   m_err;
   logic           m_valid;
   logic           m_stb;
   logic [N-1:0]   m_seen;
   int             hist[$];

   int   stb_seen   = 0;
   int   eight_hits = 0;
   logic watch8     = 1'b0;

   seg7_scan_decoder #(.NUM_DIGITS(N), .STABLE_CYCLES(STABLE)) dut (
      .clk(clk), .rst_n(rst_n), .seg_n(seg_n), .dig_n(dig_n),
      .value(value), .digit_err(digit_err), .frame_valid(frame_valid), .frame_stb(frame_stb)
   );

   always #5 clk = ~clk;

   // A sample is identified by its {dig,seg} pair; anything not driving exactly one digit becomes -1.
   function automatic int sample_key(input logic [N-1:0] d, input logic [6:0] s);
      logic [N-1:0] nd;
      int k;
      nd = ~d;
      if ($countones(nd) != 1) return -1;
      k = 0;
      k[6:0] = s;
      k[7 +: N] = d;
      return k;
   endfunction

   // Model: a digit is accepted when the newest STABLE registered samples are one identical valid
   // sample and the sample before that run (if any) was something else.
   always @(posedge clk) begin
      int run;
      int k;
      int hit;
      logic [6:0] s;
      logic [N-1:0] d;
      if (!rst_n) begin
         model_on = 1'b1;
         m_value  = '0;
         m_err    = '0;
         m_valid  = 1'b0;
         m_stb    = 1'b0;
         m_seen   = '0;
         hist.delete();
         hist.push_back(sample_key('0, '0));
      end else if (model_on) begin
         m_stb = (m_seen == '1);
         if (m_stb) begin
            m_valid = 1'b1;
            m_seen  = '0;
         end
         run = 0;
         for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i] != -1 && hist[i] == hist[hist.size() - 1]) run++;
            else break;
         end
         if (run == STABLE) begin
            k = hist[hist.size() - 1];
            s = k[6:0];
            d = k[7 +: N];
            hit = -1;
            for (int g = 0; g < 16; g++) if (glyph[g] == s) hit = g;
            for (int i = 0; i < N; i++) begin
               if (!d[i]) begin
                  if (hit >= 0) begin
                     m_value[4*i +: 4] = 4'(hit);
                     m_err[i] = 1'b0;
                  end else begin
                     m_err[i] = 1'b1;
                  end
                  m_seen[i] = 1'b1;
               end
            end
         end
         hist.push_back(sample_key(dig_n, seg_n));
         if (hist.size() > STABLE + 1) void'(hist.pop_front());
      end
   end

   // Cycle-by-cycle comparison of every output against the model.
   always @(negedge clk) begin
      if (model_on) begin
         vectors++;
         if (value !== m_value || digit_err !== m_err || frame_valid !== m_valid || frame_stb !== m_stb) begin
            miscompares++;
            $display("[TB] FAIL cycle_compare t=%0t: got value=%h err=%b valid=%b stb=%b, model value=%h err=%b valid=%b stb=%b",
                     $time, value, digit_err, frame_valid, frame_stb, m_value, m_err, m_valid, m_stb);
         end
      end
   end

   // Event counters used by directed checks; they are cleared only at negedge+1.
   always @(negedge clk) begin
      if (frame_stb === 1'b1) stb_seen++;
      if (watch8 && value[3:0] === 4'h8) eight_hits++;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [N-1:0] d, input logic [6:0] s, input int n);
      dig_n = d;
      seg_n = s;
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic showDigit(input int idx, input logic [6:0] s, input int n);
      logic [N-1:0] d;
      d = '1;
      d[idx] = 1'b0;
      applyStimulus(d, s, n);
      applyStimulus('1, 7'h7F, 2);
   endtask

   initial begin
      logic [4*N-1:0] snap_value;
      logic [N-1:0]   snap_err;
      logic [N-1:0]   d;
      int             i0;
      int             i1;
      int             kind;

      rst_n = 1'b0;
      dig_n = '1;
      seg_n = 7'h7F;
      @(negedge clk);
      #1;
      repeat (2) begin
         @(negedge clk);
         #1;
         checkOutput("reset_value", 32'(value), 32'h0);
         checkOutput("reset_err", 32'(digit_err), 32'h0);
         checkOutput("reset_valid", 32'(frame_valid), 32'h0);
         checkOutput("reset_stb", 32'(frame_stb), 32'h0);
      end

      $display("[TB] single digit latency");
      rst_n = 1'b1;
      applyStimulus(4'b1110, 7'b0000110, 8);
      checkOutput("latency_before", 32'(value[3:0]), 32'h0);
      applyStimulus(4'b1110, 7'b0000110, 1);
      checkOutput("latency_at", 32'(value[3:0]), 32'h3);
      applyStimulus(4'b1110, 7'b0000110, 1);
      applyStimulus('1, 7'h7F, 2);
      checkOutput("single_hold", 32'(value), 32'h0003);

      $display("[TB] full frame");
      stb_seen = 0;
      showDigit(0, glyph[1], 12);
      showDigit(1, glyph[2], 12);
      showDigit(2, glyph[10], 12);
      applyStimulus(4'b0111, glyph[15], 9);
      checkOutput("frame_d3_value", 32'(value[15:12]), 32'hF);
      checkOutput("frame_stb_early", 32'(frame_stb), 32'h0);
      applyStimulus(4'b0111, glyph[15], 1);
      checkOutput("frame_stb_pulse", 32'(frame_stb), 32'h1);
      applyStimulus(4'b0111, glyph[15], 2);
      applyStimulus('1, 7'h7F, 3);
      checkOutput("frame_value", 32'(value), 32'hFA21);
      checkOutput("frame_stb_count", 32'(stb_seen), 32'd1);
      checkOutput("frame_valid", 32'(frame_valid), 32'h1);

      $display("[TB] glitch rejection");
      watch8 = 1'b1;
      applyStimulus(4'b1110, glyph[8], 5);
      showDigit(0, glyph[6], 12);
      watch8 = 1'b0;
      checkOutput("glitch_never8", 32'(eight_hits), 32'd0);
      checkOutput("glitch_value", 32'(value[3:0]), 32'h6);

      $display("[TB] invalid glyph");
      showDigit(1, 7'b1111111, 10);
      checkOutput("invalid_err", 32'(digit_err[1]), 32'h1);
      checkOutput("invalid_keep", 32'(value[7:4]), 32'h2);
      showDigit(1, glyph[5], 10);
      checkOutput("recover_err", 32'(digit_err[1]), 32'h0);
      checkOutput("recover_value", 32'(value[7:4]), 32'h5);

      $display("[TB] ghosting");
      snap_value = value;
      snap_err   = digit_err;
      stb_seen   = 0;
      applyStimulus(4'b1100, 7'b0000000, 20);
      applyStimulus('1, 7'h7F, 2);
      checkOutput("ghost_value", 32'(value), 32'(snap_value));
      checkOutput("ghost_err", 32'(digit_err), 32'(snap_err));
      checkOutput("ghost_stb", 32'(stb_seen), 32'd0);

      $display("[TB] reset mid-frame");
      stb_seen = 0;
      showDigit(0, glyph[7], 10);
      showDigit(1, glyph[9], 10);
      rst_n = 1'b0;
      applyStimulus('1, 7'h7F, 1);
      rst_n = 1'b1;
      checkOutput("midreset_value", 32'(value), 32'h0);
      checkOutput("midreset_valid", 32'(frame_valid), 32'h0);
      showDigit(2, glyph[12], 10);
      showDigit(3, glyph[13], 10);
      checkOutput("midreset_no_stb", 32'(stb_seen), 32'd0);
      showDigit(0, glyph[14], 10);
      showDigit(1, glyph[11], 10);
      checkOutput("midreset_stb", 32'(stb_seen), 32'd1);
      checkOutput("midreset_frame", 32'(value), 32'hDCBE);

      $display("[TB] random scanning");
      repeat (300) begin
         kind = int'($urandom_range(0, 99));
         if (kind < 70) begin
            d = '1;
            d[$urandom_range(0, N - 1)] = 1'b0;
            if ($urandom_range(0, 9) == 0) applyStimulus(d, 7'($urandom_range(0, 127)), int'($urandom_range(1, 14)));
            else applyStimulus(d, glyph[$urandom_range(0, 15)], int'($urandom_range(1, 14)));
         end else if (kind < 85) begin
            applyStimulus('1, 7'($urandom_range(0, 127)), int'($urandom_range(1, 4)));
         end else if (kind < 95) begin
            i0 = int'($urandom_range(0, N - 1));
            i1 = (i0 + int'($urandom_range(1, N - 1))) % N;
            d = '1;
            d[i0] = 1'b0;
            d[i1] = 1'b0;
            applyStimulus(d, 7'($urandom_range(0, 127)), int'($urandom_range(1, 12)));
         end else begin
            rst_n = 1'b0;
            applyStimulus(dig_n, seg_n, int'($urandom_range(1, 2)));
            rst_n = 1'b1;
         end
      end
      applyStimulus('1, 7'h7F, 4);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
